multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I(+M) control FSM: FETCH/DECODE/EXEC/MEM/WB/MULWAIT/HALT sequencing.
// Strobes are decoded from the registered state, and rst forces them low without waiting for clk.
module multicycle_control_unit #(
  parameter int ENABLE_MUL  = 0,
  parameter int MUL_LATENCY = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       inst20,
  input  logic       funct7_0,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ALU_src,
  output logic       mem_to_reg,
  output logic       branch,
  output logic       jal,
  output logic       jalr,
  output logic       auipc,
  output logic [1:0] ALU_op,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic       mem_fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    MULWAIT = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_ARITHR = 5'b01100;
  localparam logic [4:0] OP_ARITHI = 5'b00100;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [4:0] OP_FENCE  = 5'b00011;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [3:0] MUL_LOAD    = 4'(MUL_LATENCY - 1);

  state_t     cur_state;
  logic [4:0] op_q;
  logic       f7_q;
  logic [7:0] wait_cnt;
  logic [3:0] mul_cnt;
  logic       illegal_q;
  logic       fault_q;
  logic       timeout_hit;
  logic       is_nop;

  function automatic logic op_known(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_ARITHR, OP_ARITHI,
      OP_JALR, OP_JAL, OP_AUIPC, OP_LUI:            op_known = 1'b1;
      default:                                      op_known = 1'b0;
    endcase
  endfunction

  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == TIMEOUT_CNT);
  // inst20 only matters for SYSTEM, which is fully resolved in DECODE from the live input.
  assign is_nop      = ((opcode == OP_SYSTEM) && !inst20) || (opcode == OP_FENCE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= FETCH;
      op_q      <= '0;
      f7_q      <= 1'b0;
      wait_cnt  <= '0;
      mul_cnt   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (cur_state)
        FETCH: begin
          if (mem_ready) begin
            cur_state <= DECODE;
          end else if (timeout_hit) begin
            cur_state <= HALT;
            fault_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          op_q <= opcode;
          f7_q <= funct7_0;
          if ((opcode == OP_SYSTEM) && inst20) begin
            cur_state <= HALT;
          end else if (is_nop) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
          end else if (!op_known(opcode)) begin
            cur_state <= HALT;
            illegal_q <= 1'b1;
          end else begin
            cur_state <= EXEC;
          end
        end
        EXEC: begin
          if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
            cur_state <= MEM;
            wait_cnt  <= '0;
          end else if (op_q == OP_BRANCH) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
          end else if ((op_q == OP_ARITHR) && f7_q) begin
            if (ENABLE_MUL != 0) begin
              cur_state <= MULWAIT;
              mul_cnt   <= MUL_LOAD;
            end else begin
              cur_state <= HALT;
              illegal_q <= 1'b1;
            end
          end else begin
            cur_state <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            cur_state <= (op_q == OP_STORE) ? FETCH : WB;
            wait_cnt  <= '0;
          end else if (timeout_hit) begin
            cur_state <= HALT;
            fault_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        MULWAIT: begin
          if (mul_cnt == 4'd0) cur_state <= WB;
          else                 mul_cnt   <= mul_cnt - 4'd1;
        end
        WB: begin
          cur_state <= FETCH;
          wait_cnt  <= '0;
        end
        HALT: cur_state <= HALT;
        default: begin
          cur_state <= HALT;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    ALU_src    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jal        = 1'b0;
    jalr       = 1'b0;
    auipc      = 1'b0;
    ALU_op     = 2'b00;
    if (!rst) begin
      // Datapath selects stay valid from EXEC until the instruction commits.
      if ((cur_state == EXEC) || (cur_state == MEM) ||
          (cur_state == MULWAIT) || (cur_state == WB)) begin
        case (op_q)
          OP_LOAD:   begin ALU_src = 1'b1; mem_to_reg = 1'b1; end
          OP_STORE:  ALU_src = 1'b1;
          OP_BRANCH: begin branch = 1'b1; ALU_op = 2'b01; end
          OP_ARITHR: ALU_op = 2'b10;
          OP_ARITHI: begin ALU_src = 1'b1; ALU_op = 2'b10; end
          OP_JALR:   begin ALU_src = 1'b1; jalr = 1'b1; end
          OP_JAL:    jal = 1'b1;
          OP_AUIPC:  begin ALU_src = 1'b1; auipc = 1'b1; end
          OP_LUI:    begin ALU_src = 1'b1; ALU_op = 2'b11; end
          default:   ;
        endcase
      end
      case (cur_state)
        FETCH: begin
          mem_read = !timeout_hit;
          ir_write = mem_ready;
        end
        DECODE: begin
          pc_write = is_nop;
          retire   = is_nop;
        end
        EXEC: begin
          pc_write = (op_q == OP_BRANCH);
          retire   = (op_q == OP_BRANCH);
        end
        MEM: begin
          if (op_q == OP_STORE) begin
            mem_write = !timeout_hit;
            pc_write  = mem_ready;
            retire    = mem_ready;
          end else begin
            mem_read = !timeout_hit;
          end
        end
        WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          retire    = 1'b1;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal   = illegal_q;
  assign mem_fault = fault_q;
  assign state     = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: dut_a has the M path and an 8-cycle memory timeout,
// dut_b uses defaults to show the illegal M-instruction path.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic [4:0] opcode;
  logic       inst20, funct7_0, mem_ready;

  logic       ir_write, pc_write, mem_read, mem_write, reg_write;
  logic       ALU_src, mem_to_reg, branch, jal, jalr, auipc, retire;
  logic       halted, illegal, mem_fault;
  logic [1:0] ALU_op;
  logic [2:0] state;

  logic       b_ir_write, b_pc_write, b_mem_read, b_mem_write, b_reg_write;
  logic       b_ALU_src, b_mem_to_reg, b_branch, b_jal, b_jalr, b_auipc, b_retire;
  logic       b_halted, b_illegal, b_mem_fault;
  logic [1:0] b_ALU_op;
  logic [2:0] b_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ENABLE_MUL(1), .MUL_LATENCY(4), .MEM_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .inst20(inst20), .funct7_0(funct7_0),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .ALU_src(ALU_src), .mem_to_reg(mem_to_reg),
    .branch(branch), .jal(jal), .jalr(jalr), .auipc(auipc), .ALU_op(ALU_op), .retire(retire),
    .halted(halted), .illegal(illegal), .mem_fault(mem_fault), .state(state)
  );

  multicycle_control_unit dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode), .inst20(inst20), .funct7_0(funct7_0),
    .mem_ready(mem_ready), .ir_write(b_ir_write), .pc_write(b_pc_write), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .reg_write(b_reg_write), .ALU_src(b_ALU_src),
    .mem_to_reg(b_mem_to_reg), .branch(b_branch), .jal(b_jal), .jalr(b_jalr), .auipc(b_auipc),
    .ALU_op(b_ALU_op), .retire(b_retire), .halted(b_halted), .illegal(b_illegal),
    .mem_fault(b_mem_fault), .state(b_state)
  );

  // {ir_write, pc_write, mem_read, mem_write, reg_write, retire}
  logic [5:0] strb;
  // {ALU_src, mem_to_reg, branch, jal, jalr, auipc, ALU_op}
  logic [7:0] sel;
  // {halted, illegal, mem_fault}
  logic [2:0] flags, b_flags;
  assign strb    = {ir_write, pc_write, mem_read, mem_write, reg_write, retire};
  assign sel     = {ALU_src, mem_to_reg, branch, jal, jalr, auipc, ALU_op};
  assign flags   = {halted, illegal, mem_fault};
  assign b_flags = {b_halted, b_illegal, b_mem_fault};

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4, S_MULWAIT = 3'd5, S_HALT = 3'd6;

  localparam logic [5:0] ST_NONE   = 6'b000000;
  localparam logic [5:0] ST_FWAIT  = 6'b001000;
  localparam logic [5:0] ST_FRDY   = 6'b101000;
  localparam logic [5:0] ST_COMMIT = 6'b010001;
  localparam logic [5:0] ST_RD     = 6'b001000;
  localparam logic [5:0] ST_WR     = 6'b000100;
  localparam logic [5:0] ST_WRDONE = 6'b010101;
  localparam logic [5:0] ST_WB     = 6'b010011;

  localparam logic [7:0] SL_NONE = 8'b0000_0000;
  localparam logic [7:0] SL_ARI  = 8'b1000_0010;
  localparam logic [7:0] SL_LOAD = 8'b1100_0000;
  localparam logic [7:0] SL_STOR = 8'b1000_0000;
  localparam logic [7:0] SL_BRA  = 8'b0010_0001;
  localparam logic [7:0] SL_ARR  = 8'b0000_0010;
  localparam logic [7:0] SL_LUI  = 8'b1000_0011;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; checks at the following negedge and returns at the next posedge+1.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] sb,
                     input logic [7:0] sl);
    @(negedge clk);
    chk({tag, ".state"}, {5'b0, state}, {5'b0, st});
    chk({tag, ".strobes"}, {2'b0, strb}, {2'b0, sb});
    chk({tag, ".selects"}, sel, sl);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [4:0] op, input logic i20,
                              input logic f7, input logic [5:0] dec_sb);
    mem_ready = 1'b1;
    cyc({tag, ".fetch"}, S_FETCH, ST_FRDY, SL_NONE);
    opcode = op; inst20 = i20; funct7_0 = f7;
    cyc({tag, ".decode"}, S_DECODE, dec_sb, SL_NONE);
    opcode = 5'b11111; inst20 = 1'b1; funct7_0 = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #2;
    chk({tag, ".rst_state"}, {5'b0, state}, {5'b0, S_FETCH});
    chk({tag, ".rst_strobes"}, {2'b0, strb}, 8'h00);
    chk({tag, ".rst_flags"}, {5'b0, flags}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    opcode = '0; inst20 = 1'b0; funct7_0 = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.state", {5'b0, state}, 8'h00);
    chk("reset.strobes", {2'b0, strb}, 8'h00);
    chk("reset.selects", sel, 8'h00);
    chk("reset.flags", {5'b0, flags}, 8'h00);
    rst = 1'b0; rst_b = 1'b0;

    // Arith_I with mem_ready always high: 4 cycles, opcode latched in DECODE.
    fetch_decode("arith_i", 5'b00100, 1'b0, 1'b0, ST_NONE);
    cyc("arith_i.exec", S_EXEC, ST_NONE, SL_ARI);
    cyc("arith_i.wb", S_WB, ST_WB, SL_ARI);

    // Load with three not-ready cycles in MEM.
    fetch_decode("load", 5'b00000, 1'b0, 1'b0, ST_NONE);
    mem_ready = 1'b0;
    cyc("load.exec", S_EXEC, ST_NONE, SL_LOAD);
    for (int i = 0; i < 3; i++) cyc("load.memwait", S_MEM, ST_RD, SL_LOAD);
    mem_ready = 1'b1;
    cyc("load.memdone", S_MEM, ST_RD, SL_LOAD);
    mem_ready = 1'b0;
    cyc("load.wb", S_WB, ST_WB, SL_LOAD);

    // Store completing on first MEM cycle, then Branch and LUI.
    fetch_decode("store", 5'b01000, 1'b0, 1'b0, ST_NONE);
    cyc("store.exec", S_EXEC, ST_NONE, SL_STOR);
    cyc("store.mem", S_MEM, ST_WRDONE, SL_STOR);
    fetch_decode("branch", 5'b11000, 1'b0, 1'b0, ST_NONE);
    cyc("branch.exec", S_EXEC, ST_COMMIT, SL_BRA);
    fetch_decode("lui", 5'b01101, 1'b0, 1'b0, ST_NONE);
    cyc("lui.exec", S_EXEC, ST_NONE, SL_LUI);
    cyc("lui.wb", S_WB, ST_WB, SL_LUI);

    // ECALL and FENCE retire as two-cycle NOPs.
    fetch_decode("ecall", 5'b11100, 1'b0, 1'b0, ST_COMMIT);
    fetch_decode("fence", 5'b00011, 1'b0, 1'b0, ST_COMMIT);

    // M-extension: dut_a spends 4 cycles in MULWAIT; dut_b halts as illegal.
    fetch_decode("mul", 5'b01100, 1'b0, 1'b1, ST_NONE);
    cyc("mul.exec", S_EXEC, ST_NONE, SL_ARR);
    chk("mul.b_state", {5'b0, b_state}, {5'b0, S_HALT});
    chk("mul.b_flags", {5'b0, b_flags}, 8'b0000_0110);
    for (int i = 0; i < 4; i++) cyc("mul.wait", S_MULWAIT, ST_NONE, SL_ARR);
    cyc("mul.wb", S_WB, ST_WB, SL_ARR);
    chk("mul.b_strobes", {2'b0, b_ir_write, b_pc_write, b_mem_read, b_mem_write, b_reg_write,
                          b_retire}, 8'h00);

    // EBREAK halts without illegal; HALT ignores mem_ready.
    fetch_decode("ebreak", 5'b11100, 1'b1, 1'b0, ST_NONE);
    cyc("ebreak.halt", S_HALT, ST_NONE, SL_NONE);
    chk("ebreak.flags", {5'b0, flags}, 8'b0000_0100);
    mem_ready = 1'b0;
    cyc("ebreak.stay", S_HALT, ST_NONE, SL_NONE);
    pulse_reset("ebreak");

    // Unlisted opcode halts with illegal set.
    fetch_decode("badop", 5'b11111, 1'b0, 1'b0, ST_NONE);
    cyc("badop.halt", S_HALT, ST_NONE, SL_NONE);
    chk("badop.flags", {5'b0, flags}, 8'b0000_0110);
    pulse_reset("badop");

    // Asynchronous reset in the middle of a store drops mem_write before any clock edge.
    fetch_decode("astore", 5'b01000, 1'b0, 1'b0, ST_NONE);
    mem_ready = 1'b0;
    cyc("astore.exec", S_EXEC, ST_NONE, SL_STOR);
    @(negedge clk);
    chk("astore.mem_write_before", {2'b0, strb}, {2'b0, ST_WR});
    #2;
    rst = 1'b1;
    #1;
    chk("astore.mem_write_async", {7'b0, mem_write}, 8'h00);
    chk("astore.state_async", {5'b0, state}, {5'b0, S_FETCH});
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("astore.next_fetch", S_FETCH, ST_FWAIT, SL_NONE);
    pulse_reset("astore");

    // Fetch timeout: 8 waiting cycles, a strobe-free transition cycle, then HALT with mem_fault.
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc("tmo.wait", S_FETCH, ST_FWAIT, SL_NONE);
    cyc("tmo.trans", S_FETCH, ST_NONE, SL_NONE);
    cyc("tmo.halt", S_HALT, ST_NONE, SL_NONE);
    chk("tmo.flags", {5'b0, flags}, 8'b0000_0101);
    pulse_reset("tmo");
    cyc("tmo.restart", S_FETCH, ST_FWAIT, SL_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
